// File: rtl/seq_detect_param.sv
// Serial sequence detector: compares the last WIDTH valid bits against a
// runtime-loadable pattern, with overlap control and a saturating match count.
module seq_detect_param #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = 8'b10011011,
    parameter int               CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inp,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    output logic             error,
    output logic             match_op,
    output logic [CNT_W-1:0] match_count
);

    localparam int             FW   = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]  FULL = FW'(WIDTH);

    logic [WIDTH-1:0] pat, pat_n;
    logic [WIDTH-1:0] hist, hist_n;
    logic [WIDTH-1:0] nh;
    logic [FW-1:0]    fill, fill_n;
    logic [FW-1:0]    nf;
    logic [CNT_W-1:0] count_n;
    logic             match_n;
    logic             error_n;
    logic             bad;
    logic             hit;

    // Only meaningful in a four-state simulation; a real pin is always 0 or 1.
    assign bad = (inp !== 1'b0) && (inp !== 1'b1);

    always_comb begin
        pat_n   = pat;
        hist_n  = hist;
        fill_n  = fill;
        count_n = match_count;
        match_n = 1'b0;
        error_n = 1'b0;
        nh      = {hist[WIDTH-2:0], inp};
        nf      = (fill == FULL) ? FULL : fill + 1'b1;
        // fill guards against the reset zeros in hist posing as received bits
        hit     = (nf == FULL) && (nh == pat);

        if (load) begin
            pat_n   = pattern_in;
            hist_n  = '0;
            fill_n  = '0;
            count_n = '0;
        end else if (en) begin
            if (bad) begin
                error_n = 1'b1;
                hist_n  = '0;
                fill_n  = '0;
            end else if (hit) begin
                match_n = 1'b1;
                if (!(&match_count)) begin
                    count_n = match_count + 1'b1;
                end
                if (overlap) begin
                    hist_n = nh;
                    fill_n = nf;
                end else begin
                    hist_n = '0;
                    fill_n = '0;
                end
            end else begin
                hist_n = nh;
                fill_n = nf;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat         <= DEFAULT_PAT;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
            match_op    <= 1'b0;
            error       <= 1'b0;
        end else begin
            pat         <= pat_n;
            hist        <= hist_n;
            fill        <= fill_n;
            match_count <= count_n;
            match_op    <= match_n;
            error       <= error_n;
        end
    end

endmodule
